// File: rtl/mem_rsp.sv
// MemBus target: in-order request queue in front of a 64 x 8 storage array,
// reads answered after LATENCY wait cycles. Optional: MEM_RSP_WRITE_ACK_EN.
module mem_rsp #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_op,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_vld,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic [5:0]      addr_q;
  logic            rsp_vld_q;
  logic [7:0]      rsp_data_q;
  logic            ovf_q;
  logic [7:0]      mem_q [64];

  logic [15:0]     q_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push_req, push, pop, full;
  logic [15:0]     head;
  logic [1:0]      head_op;
  logic [5:0]      head_addr;
  logic [7:0]      head_data;

  assign push_req  = (req_op == OP_READ) || (req_op == OP_WRITE);
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  // A pop on the same edge frees a slot, so a full queue still accepts then.
  assign push      = push_req && (!full || pop);

  assign head      = q_mem[rd_ptr_q];
  assign head_op   = head[15:14];
  assign head_addr = head[13:8];
  assign head_data = head[7:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr_q] <= {req_op, req_addr, req_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < 64; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_req && !push) ovf_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head_op == OP_WRITE) begin
              mem_q[head_addr] <= head_data;
`ifdef MEM_RSP_WRITE_ACK_EN
              // No pop occurs until RESP ends, so mem[addr] still holds this
              // write's data when the shared read path samples it.
              addr_q  <= head_addr;
              cnt_q   <= 4'(LATENCY - 1);
              state_q <= S_WAIT;
`endif
            end else begin
              addr_q  <= head_addr;
              cnt_q   <= 4'(LATENCY - 1);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q <= mem_q[addr_q];
            rsp_vld_q  <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          rsp_vld_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_mem_rsp.sv
// Directed bench for mem_rsp: reset, write/read, ordering, overflow,
// mid-flight reset and (with MEM_RSP_WRITE_ACK_EN) write acknowledges.
module tb_mem_rsp;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_op = 2'd0;
  logic [5:0] req_addr = 6'd0;
  logic [7:0] req_data = 8'd0;
  logic       rsp_vld;
  logic [7:0] rsp_data;
  logic       busy;
  logic       ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulses = 0;
  logic [7:0] rsp_log[$];
  int         rsp_t[$];

  mem_rsp #(.LATENCY(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // A response pulse spans exactly one negedge, tagged with the edge that loaded it.
  always @(negedge clk) begin
    if (rsp_vld === 1'b1) begin
      pulses++;
      rsp_log.push_back(rsp_data);
      rsp_t.push_back(cyc);
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] a,
                       input logic [7:0] d, output int n);
    @(negedge clk);
    req_op = op; req_addr = a; req_data = d;
    @(posedge clk);
    #1;
    n = cyc;
    req_op = 2'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 200) begin
      wait_edges(1);
      k++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
    wait_edges(1);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL reset_vld: got %b want 0", rsp_vld); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", rsp_data); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    wait_edges(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", busy); end
    issue(2'd1, 6'h00, 8'h00, n);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL read_busy: got %b want 1", busy); end
    wait_edges(4);
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL read_early_vld: got %b want 0 at N+5", rsp_vld); end
    wait_edges(1);
    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL read_vld: got %b want 1 at N+6", rsp_vld); end
    vectors++; if (rsp_data !== 8'h00) begin miscompares++; $display("FAIL read_data: got %h want 00", rsp_data); end
    wait_edges(1);
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL read_late_vld: got %b want 0 at N+7", rsp_vld); end
    $display("test_reset: read 0x00 issued at edge %0d", n);
  endtask

  task automatic test_write_read();
    int n, nw;
    rsp_log.delete(); rsp_t.delete();
    issue(2'd2, 6'h2A, 8'h5C, nw);
    wait_edges(2);
    issue(2'd1, 6'h2A, 8'h00, n);
    wait_idle();
    vectors++;
    if (rsp_log.size() == 0 || rsp_log[rsp_log.size()-1] !== 8'h5C) begin
      miscompares++;
      $display("FAIL wr_rd_data: got %0d responses, last %h, want last 5c", rsp_log.size(),
               (rsp_log.size() == 0) ? 8'hxx : rsp_log[rsp_log.size()-1]);
    end
`ifndef MEM_RSP_WRITE_ACK_EN
    vectors++;
    if (rsp_log.size() != 1) begin miscompares++; $display("FAIL wr_rd_count: got %0d responses want 1", rsp_log.size()); end
    vectors++;
    if (rsp_t.size() == 0 || rsp_t[0] != n + 5) begin
      miscompares++;
      $display("FAIL wr_rd_time: got edge %0d want %0d", (rsp_t.size() == 0) ? -1 : rsp_t[0], n + 5);
    end
`endif
    $display("test_write_read: write at %0d, read at %0d, %0d responses", nw, n, rsp_log.size());
  endtask

  task automatic test_back_to_back();
    int n0, n;
    logic [7:0] exp[$];
    rsp_log.delete(); rsp_t.delete();
    issue(2'd2, 6'h01, 8'h11, n0);
    issue(2'd1, 6'h01, 8'h00, n);
    issue(2'd2, 6'h01, 8'h22, n);
    issue(2'd1, 6'h01, 8'h00, n);
    wait_idle();
`ifdef MEM_RSP_WRITE_ACK_EN
    exp = '{8'h11, 8'h11, 8'h22, 8'h22};
`else
    exp = '{8'h11, 8'h22};
    vectors++;
    if (rsp_t.size() != 2 || rsp_t[0] != n0 + 6 || rsp_t[1] != n0 + 13) begin
      miscompares++;
      $display("FAIL b2b_time: got %0d responses, first edges %0d/%0d want %0d/%0d", rsp_t.size(),
               (rsp_t.size() > 0) ? rsp_t[0] : -1, (rsp_t.size() > 1) ? rsp_t[1] : -1, n0 + 6, n0 + 13);
    end
`endif
    vectors++;
    if (rsp_log.size() != exp.size()) begin
      miscompares++; $display("FAIL b2b_count: got %0d want %0d", rsp_log.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (i >= rsp_log.size() || rsp_log[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, (i < rsp_log.size()) ? rsp_log[i] : 8'hxx, exp[i]);
      end
    end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf: got %b want 0", ovf); end
    $display("test_back_to_back: %0d responses", rsp_log.size());
  endtask

  task automatic test_overflow();
    int n0, n;
    for (int i = 0; i < 6; i++) begin
      issue(2'd2, 6'(6'h10 + i), 8'(8'hB0 + i), n);
      wait_idle();
    end
    rsp_log.delete(); rsp_t.delete();
    issue(2'd1, 6'h10, 8'h00, n0);
    for (int i = 1; i < 5; i++) issue(2'd1, 6'(6'h10 + i), 8'h00, n);
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0 after 5th read", ovf); end
    issue(2'd1, 6'h15, 8'h00, n);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b want 1 after 6th read", ovf); end
    wait_idle();
    vectors++;
    if (rsp_log.size() != 5) begin miscompares++; $display("FAIL ovf_count: got %0d responses want 5", rsp_log.size()); end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= rsp_log.size() || rsp_log[i] !== 8'(8'hB0 + i) || rsp_t[i] != n0 + 5 + 6 * i) begin
        miscompares++;
        $display("FAIL ovf_rsp[%0d]: got %h at edge %0d want %h at edge %0d", i,
                 (i < rsp_log.size()) ? rsp_log[i] : 8'hxx, (i < rsp_t.size()) ? rsp_t[i] : -1,
                 8'(8'hB0 + i), n0 + 5 + 6 * i);
      end
    end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    $display("test_overflow: %0d responses, ovf=%b", rsp_log.size(), ovf);
  endtask

  task automatic test_reset_midflight();
    int n, p0;
    issue(2'd2, 6'h33, 8'h77, n);
    wait_idle();
    p0 = pulses;
    issue(2'd1, 6'h33, 8'h00, n);
    wait_edges(2);
    #1 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rst_vld: got %b want 0", rsp_vld); end
    @(negedge clk);
    rst = 1'b0;
    wait_edges(10);
    vectors++; if (pulses != p0) begin miscompares++; $display("FAIL rst_no_rsp: got %0d pulses want %0d", pulses, p0); end
    rsp_log.delete(); rsp_t.delete();
    issue(2'd1, 6'h33, 8'h00, n);
    wait_idle();
    vectors++;
    if (rsp_log.size() != 1 || rsp_log[0] !== 8'h00 || rsp_t[0] != n + 5) begin
      miscompares++;
      $display("FAIL rst_cleared: got %0d responses, first %h at edge %0d, want 00 at edge %0d", rsp_log.size(),
               (rsp_log.size() > 0) ? rsp_log[0] : 8'hxx, (rsp_t.size() > 0) ? rsp_t[0] : -1, n + 5);
    end
    $display("test_reset_midflight: post-reset read of 0x33 returned %0d responses", rsp_log.size());
  endtask

`ifdef MEM_RSP_WRITE_ACK_EN
  task automatic test_write_ack();
    int n;
    rsp_log.delete(); rsp_t.delete();
    issue(2'd2, 6'h3F, 8'hA5, n);
    wait_idle();
    vectors++;
    if (rsp_log.size() != 1 || rsp_log[0] !== 8'hA5 || rsp_t[0] != n + 5) begin
      miscompares++;
      $display("FAIL wack_rsp: got %0d responses, first %h at edge %0d, want a5 at edge %0d", rsp_log.size(),
               (rsp_log.size() > 0) ? rsp_log[0] : 8'hxx, (rsp_t.size() > 0) ? rsp_t[0] : -1, n + 5);
    end
    rsp_log.delete(); rsp_t.delete();
    issue(2'd1, 6'h3F, 8'h00, n);
    wait_idle();
    vectors++;
    if (rsp_log.size() != 1 || rsp_log[0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL wack_read: got %0d responses, first %h, want a5", rsp_log.size(),
               (rsp_log.size() > 0) ? rsp_log[0] : 8'hxx);
    end
    $display("test_write_ack: write 0x3F acknowledged");
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_overflow();
    test_reset_midflight();
`ifdef MEM_RSP_WRITE_ACK_EN
    test_write_ack();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_rsp.md
# mem_rsp

Backing-memory responder for the MemBus request/response protocol: the target end of the interface driven by the cache or bench initiator. It accepts `req_op`/`req_addr`/`req_data` one-cycle requests, buffers them in an in-order request queue, and applies them to a 64 x 8-bit storage array. Each read returns after a fixed configurable latency as a one-cycle `rsp_vld` pulse. The block sits on the memory side of the cache and also serves as the reference memory model in cache benches.

## Interface
- `LATENCY`, 4: wait cycles spent in WAIT per read (legal 1..15).
- `DEPTH`, 4: request-queue entries (power of two, >= 2).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `req_op`  in  2  operation select: `Op_INVALID`=2'd0, `Op_READ`=2'd1, `Op_WRITE`=2'd2; 2'd3 is ignored, same as INVALID.
- `req_addr`  in  6  word address.
- `req_data`  in  8  write data; ignored for reads.
- `rsp_vld`  out  1  response valid, one-cycle pulse.
- `rsp_data`  out  8  response data; meaningful only while `rsp_vld` is high.
- `busy`  out  1  high when the FSM is not in IDLE or the queue is non-empty.
- `ovf`  out  1  sticky overflow flag: a request was dropped.

## Operation
- Reset, asynchronous: `rsp_vld`=0, `rsp_data`=0, `ovf`=0, `busy`=0, queue empty, pointers 0, FSM=IDLE, all 64 array entries = 8'h00.
- Accept: on every edge where `req_op` is READ or WRITE, push {op, addr, data} to the queue tail.
  - Queue full with no pop on that edge: drop the request and set `ovf`. `ovf` stays set until `rst`.
  - Push and pop on the same edge when full: the push is accepted.
- Queue is circular; pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- FSM states: IDLE, WAIT, RESP.
- IDLE with queue non-empty pops the head on the edge:
  - WRITE: `mem[addr] <= data` on that edge; stay in IDLE. One write per cycle is sustained.
  - READ: latch addr, set `cnt <= LATENCY-1`, go to WAIT.
- WAIT: `cnt` decrements each edge.
  - On the edge where `cnt`==0: `rsp_data <= mem[addr]`, `rsp_vld <= 1`, go to RESP.
- RESP: `rsp_vld` is high for this one cycle. The next edge clears `rsp_vld`, holds `rsp_data`, and returns to IDLE. No pop happens in RESP.
- Ordering: operations take effect strictly in acceptance order. A read returns the array contents after all earlier-accepted writes and before all later ones.
- `rsp_data` holds its last value when `rsp_vld` is low.
- `rst` mid-operation, in any state: immediate return to reset values. No response is emitted for in-flight or queued requests.

## Timing
- Request sampled at edge N with the responder idle and the queue empty:
  - pop at N+1
  - WAIT from N+1 to N+LATENCY
  - response loaded at N+LATENCY+1
  - `rsp_vld` sampled high at edge N+LATENCY+2 only
- Default LATENCY=4: `rsp_vld` is high at edge N+6.
- Queued reads: each additional read adds LATENCY+2 cycles of turnaround.
- Writes in the queue each cost one IDLE cycle.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- `MEM_RSP_WRITE_ACK_EN` defined:
  - A popped WRITE updates the array at pop, then follows the read path: WAIT for LATENCY cycles, then RESP.
  - `rsp_data` = the written data, so each write produces one `rsp_vld` pulse at the same latency as a read.
- Undefined: writes complete silently in one IDLE cycle and never assert `rsp_vld`.

## Test plan
- Reset, then READ 0x00 at edge N -> `rsp_vld`=1 with `rsp_data`=0x00 at edge N+6. Before the read, all outputs are 0 and `busy`=0.
- WRITE 0x2A=0x5C, then READ 0x2A three cycles later -> `rsp_data`=0x5C; no `rsp_vld` pulse for the write (macro undefined).
- Back-to-back on consecutive cycles: WRITE 0x01=0x11, READ 0x01, WRITE 0x01=0x22, READ 0x01 -> two responses in order, 0x11 then 0x22; `ovf`=0.
- Six consecutive READs (0x10..0x15, array preloaded with 0xB0..0xB5), DEPTH=4:
  - five responses 0xB0..0xB4, spaced 6 cycles apart
  - sixth read dropped and `ovf`=1 from the edge after its request
- Assert `rst` during WAIT of a pending READ -> `rsp_vld` never pulses, `busy`=0, `ovf`=0; a later READ of a previously written address returns 0x00.
- With `MEM_RSP_WRITE_ACK_EN`: WRITE 0x3F=0xA5 at edge N -> `rsp_vld`=1 with `rsp_data`=0xA5 at edge N+6; a following READ 0x3F returns 0xA5.
